plab4_net_router_credit_bubble: RTL

- Next-generation 3-port ring router: west (port 0), terminal (port 1), east (port 2).
- Ring links use credit-based flow control with parametrised input buffer depth; the terminal ports keep val/rdy.
- Routing is minimal-distance; ties are broken toward the less congested direction.
- Injection is deadlock-free via bubble flow control: a terminal packet enters a ring direction only if at least 2 downstream credits remain.
- Instantiated p_num_routers times to form the ring network.

---
 rtl/plab4_net_router_credit_bubble_pkg.sv | 34 +++
 rtl/plab4_net_router_credit_bubble_if.sv | 15 +
 rtl/plab4_net_router_credit_bubble_out_ctrl.sv | 103 ++++++++++
 rtl/plab4_net_router_credit_bubble.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/plab4_net_router_credit_bubble_pkg.sv
// Shared definitions for the credit/bubble ring router.
//   port_e            : port indices WEST=0, TERM=1, EAST=2
//   msg_*_lsb         : bit offsets of the message fields {dest, src, opaque, payload}
//   credit_nbits      : width of a counter that holds 0..depth
package plab4_net_router_credit_bubble_pkg;

  typedef enum logic [1:0] {
    WEST = 2'd0,
    TERM = 2'd1,
    EAST = 2'd2
  } port_e;

  function automatic int msg_payload_lsb();
    return 0;
  endfunction

  function automatic int msg_opaque_lsb(input int payload_nbits);
    return payload_nbits;
  endfunction

  function automatic int msg_src_lsb(input int opaque_nbits, input int payload_nbits);
    return opaque_nbits + payload_nbits;
  endfunction

  function automatic int msg_dest_lsb(input int srcdest_nbits, input int opaque_nbits,
                                      input int payload_nbits);
    return srcdest_nbits + opaque_nbits + payload_nbits;
  endfunction

  function automatic int credit_nbits(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/plab4_net_router_credit_bubble_if.sv
// One router link. Ring links use val/msg forward and credit backward;
// terminal links use val/msg forward and rdy backward.
//   master : drives val, msg; receives rdy, credit
//   slave  : receives val, msg; drives rdy, credit
interface plab4_net_router_credit_bubble_if #(
  parameter int p_msg_nbits = 41
);
  logic                   val;
  logic                   rdy;
  logic                   credit;
  logic [p_msg_nbits-1:0] msg;

  modport master (output val, output msg, input rdy, input credit);
  modport slave  (input val, input msg, output rdy, output credit);
endinterface

// File: rtl/plab4_net_router_credit_bubble_out_ctrl.sv
// Per-output control: downstream credit counter, eligibility masking,
// three-way round-robin arbiter and crossbar select.
//   clk, reset : clock, synchronous active-high reset
//   req        : per-input request for this output (queue head routed here)
//   head_msg   : the three queue heads
//   rdy        : downstream ready (terminal output only)
//   credit     : credit return from the neighbour (ring outputs only)
//   val, msg   : output flit
//   grant      : one-hot grant, doubles as the dequeue of the chosen input
//   credits    : current credit count
module plab4_net_router_credit_bubble_out_ctrl
  import plab4_net_router_credit_bubble_pkg::*;
#(
  parameter int    p_msg_nbits   = 41,
  parameter int    p_queue_depth = 4,
  parameter port_e p_port        = WEST,
  localparam int   c_cnt_nbits   = credit_nbits(p_queue_depth)
)(
  input  logic                        clk,
  input  logic                        reset,
  input  logic [2:0]                  req,
  input  logic [2:0][p_msg_nbits-1:0] head_msg,
  input  logic                        rdy,
  input  logic                        credit,
  output logic                        val,
  output logic [p_msg_nbits-1:0]      msg,
  output logic [2:0]                  grant,
  output logic [c_cnt_nbits-1:0]      credits
);

  localparam logic [c_cnt_nbits-1:0] c_full = c_cnt_nbits'(p_queue_depth);
  localparam logic [c_cnt_nbits-1:0] c_one  = c_cnt_nbits'(1);
  localparam logic [c_cnt_nbits-1:0] c_two  = c_cnt_nbits'(2);

  logic [2:0] elig;
  logic [1:0] ptr;

  // Terminal injection into a ring must leave one free slot downstream
  // (bubble), so it needs two credits where passthrough needs one.
  always_comb begin
    elig = '0;
    if (p_port == TERM) begin
      elig = req & {3{rdy}};
    end else begin
      elig[WEST] = req[WEST] && (credits >= c_one);
      elig[TERM] = req[TERM] && (credits >= c_two);
      elig[EAST] = req[EAST] && (credits >= c_one);
    end
  end

  always_comb begin
    grant = '0;
    case (ptr)
      2'd1: begin
        if      (elig[1]) grant = 3'b010;
        else if (elig[2]) grant = 3'b100;
        else if (elig[0]) grant = 3'b001;
      end
      2'd2: begin
        if      (elig[2]) grant = 3'b100;
        else if (elig[0]) grant = 3'b001;
        else if (elig[1]) grant = 3'b010;
      end
      default: begin
        if      (elig[0]) grant = 3'b001;
        else if (elig[1]) grant = 3'b010;
        else if (elig[2]) grant = 3'b100;
      end
    endcase
  end

  always_comb begin
    msg = '0;
    if      (grant[0]) msg = head_msg[0];
    else if (grant[1]) msg = head_msg[1];
    else if (grant[2]) msg = head_msg[2];
  end

  assign val = |grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr     <= 2'd0;
      credits <= c_full;
    end else begin
      if      (grant[0]) ptr <= 2'd1;
      else if (grant[1]) ptr <= 2'd2;
      else if (grant[2]) ptr <= 2'd0;
      // The terminal output is rdy-controlled; its counter stays parked.
      if (p_port != TERM) begin
        if (val && !credit)      credits <= credits - c_one;
        else if (credit && !val) credits <= credits + c_one;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && p_port != TERM) begin
      assert (!(credit && !val && credits == c_full));
    end
  end

endmodule

// File: rtl/plab4_net_router_credit_bubble.sv
// Three-port ring router (west=0, terminal=1, east=2) with credit flow
// control on the ring links and bubble-rule injection from the terminal.
//   clk, reset : clock, synchronous active-high reset
//   in0, in2   : ring inputs (val/msg in, credit pulse out on dequeue)
//   in1        : terminal inject (val/msg in, rdy out)
//   out0, out2 : ring outputs (val/msg out, credit return in)
//   out1       : terminal eject (val/msg out, rdy in)
module plab4_net_router_credit_bubble
  import plab4_net_router_credit_bubble_pkg::*;
#(
  parameter int p_payload_nbits = 32,
  parameter int p_opaque_nbits  = 3,
  parameter int p_srcdest_nbits = 3,
  parameter int p_router_id     = 0,
  parameter int p_num_routers   = 8,
  parameter int p_queue_depth   = 4
)(
  input logic clk,
  input logic reset,
  plab4_net_router_credit_bubble_if.slave  in0,
  plab4_net_router_credit_bubble_if.slave  in1,
  plab4_net_router_credit_bubble_if.slave  in2,
  plab4_net_router_credit_bubble_if.master out0,
  plab4_net_router_credit_bubble_if.master out1,
  plab4_net_router_credit_bubble_if.master out2
);

  localparam int c_msg_nbits = p_srcdest_nbits*2 + p_opaque_nbits + p_payload_nbits;
  localparam int c_dest_lsb  = msg_dest_lsb(p_srcdest_nbits, p_opaque_nbits, p_payload_nbits);
  localparam int c_cnt_nbits = credit_nbits(p_queue_depth);
  localparam int c_ptr_nbits = $clog2(p_queue_depth);
  localparam logic [c_cnt_nbits-1:0] c_full = c_cnt_nbits'(p_queue_depth);
  localparam logic [c_cnt_nbits-1:0] c_one  = c_cnt_nbits'(1);
  localparam logic [c_ptr_nbits-1:0] c_last = c_ptr_nbits'(p_queue_depth - 1);

  logic [2:0]                  in_val, enq, deq, head_val, full;
  logic [2:0][c_msg_nbits-1:0] in_msg, head_msg;
  logic [c_msg_nbits-1:0]      q_mem  [3][p_queue_depth];
  logic [c_ptr_nbits-1:0]      rd_ptr [3];
  logic [c_ptr_nbits-1:0]      wr_ptr [3];
  logic [c_cnt_nbits-1:0]      q_cnt  [3];

  port_e                  route_port [3];
  logic                   west_more;
  logic [2:0]             req_west, req_term, req_east;
  logic [2:0]             grant_west, grant_term, grant_east;
  logic [c_cnt_nbits-1:0] credits_west, credits_term, credits_east;

  function automatic logic [c_ptr_nbits-1:0] ptr_inc(input logic [c_ptr_nbits-1:0] p);
    if (p == c_last) return '0;
    return p + c_ptr_nbits'(1);
  endfunction

  // Ring traffic never turns around: it either ejects here or keeps going.
  function automatic port_e route(input port_e src, input logic [p_srcdest_nbits-1:0] dest,
                                  input logic wmore);
    int de;
    int dw;
    de = (int'(dest) - p_router_id + p_num_routers) % p_num_routers;
    dw = p_num_routers - de;
    if (int'(dest) == p_router_id) return TERM;
    if (src == WEST) return EAST;
    if (src == EAST) return WEST;
    if (de < dw) return EAST;
    if (dw < de) return WEST;
    if (wmore) return WEST;
    return EAST;
  endfunction

  assign in_val = {in2.val, in1.val, in0.val};
  assign in_msg = {in2.msg, in1.msg, in0.msg};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      full[i]     = (q_cnt[i] == c_full);
      head_val[i] = (q_cnt[i] != '0);
      head_msg[i] = q_mem[i][rd_ptr[i]];
      enq[i]      = in_val[i] && !full[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        q_cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (enq[i]) begin
          q_mem[i][wr_ptr[i]] <= in_msg[i];
          wr_ptr[i]           <= ptr_inc(wr_ptr[i]);
        end
        if (deq[i]) rd_ptr[i] <= ptr_inc(rd_ptr[i]);
        if (enq[i] && !deq[i])      q_cnt[i] <= q_cnt[i] + c_one;
        else if (deq[i] && !enq[i]) q_cnt[i] <= q_cnt[i] - c_one;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(in0.val && full[WEST]));
      assert (!(in2.val && full[EAST]));
      assert (credits_term == c_full);
    end
  end

  assign west_more = credits_west > credits_east;

  always_comb begin
    route_port[0] = route(WEST, head_msg[0][c_dest_lsb +: p_srcdest_nbits], west_more);
    route_port[1] = route(TERM, head_msg[1][c_dest_lsb +: p_srcdest_nbits], west_more);
    route_port[2] = route(EAST, head_msg[2][c_dest_lsb +: p_srcdest_nbits], west_more);
  end

  // Requests are masked during reset so nothing leaves or dequeues.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      req_west[i] = head_val[i] && !reset && (route_port[i] == WEST);
      req_term[i] = head_val[i] && !reset && (route_port[i] == TERM);
      req_east[i] = head_val[i] && !reset && (route_port[i] == EAST);
    end
  end

  assign deq = grant_west | grant_term | grant_east;

  assign in0.credit = deq[0];
  assign in0.rdy    = 1'b1;
  assign in1.credit = 1'b0;
  assign in1.rdy    = !full[1] && !reset;
  assign in2.credit = deq[2];
  assign in2.rdy    = 1'b1;

  plab4_net_router_credit_bubble_out_ctrl #(
    .p_msg_nbits(c_msg_nbits), .p_queue_depth(p_queue_depth), .p_port(WEST)
  ) u_out_west (
    .clk(clk), .reset(reset), .req(req_west), .head_msg(head_msg),
    .rdy(out0.rdy), .credit(out0.credit), .val(out0.val), .msg(out0.msg),
    .grant(grant_west), .credits(credits_west)
  );

  plab4_net_router_credit_bubble_out_ctrl #(
    .p_msg_nbits(c_msg_nbits), .p_queue_depth(p_queue_depth), .p_port(TERM)
  ) u_out_term (
    .clk(clk), .reset(reset), .req(req_term), .head_msg(head_msg),
    .rdy(out1.rdy), .credit(out1.credit), .val(out1.val), .msg(out1.msg),
    .grant(grant_term), .credits(credits_term)
  );

  plab4_net_router_credit_bubble_out_ctrl #(
    .p_msg_nbits(c_msg_nbits), .p_queue_depth(p_queue_depth), .p_port(EAST)
  ) u_out_east (
    .clk(clk), .reset(reset), .req(req_east), .head_msg(head_msg),
    .rdy(out2.rdy), .credit(out2.credit), .val(out2.val), .msg(out2.msg),
    .grant(grant_east), .credits(credits_east)
  );

endmodule
